// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS MEM-stage memories: access sizes, data-memory FSM states and the
// misalignment rule used by both the data memory and the future cache.
package mips_mem_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } dmem_state_e;

  // Size 2'b11 is reserved and behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-lane select and sign/zero extension: picks the byte/half/word addressed by i_off from a
// little-endian word and extends it to 32 bits.
module dmem_load_align
  import mips_mem_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [1:0]        i_off,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [WORD_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  always_comb begin
    w_byte = i_word[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    w_sign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        w_sign = ~i_unsigned & w_byte[7];
        o_data = {{24{w_sign}}, w_byte};
      end
      SZ_HALF: begin
        w_sign = ~i_unsigned & w_half[15];
        o_data = {{16{w_sign}}, w_half};
      end
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed MEM-stage data memory with sized loads/stores, two-edge registered load path and
// an optional post-reset clear engine enabled by the DMEM_CLEAR_EN macro.
module data_mem_sized
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_re,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned_ld,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_misalign,
  output logic        o_busy,
  output logic [15:0] o_test_value
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_accept;
  logic              w_mis;
  logic              w_store;
  logic              w_load;
  logic [ADDR_W-1:0] w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wlanes;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_unused;

  logic              r_p1_load;
  logic              r_p1_mis;
  logic [WORD_W-1:0] r_p1_word;
  logic [1:0]        r_p1_off;
  logic [1:0]        r_p1_size;
  logic              r_p1_uns;
  logic [WORD_W-1:0] w_ld_data;

  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_misalign;

  // Upper address bits wrap the array modulo DEPTH.
  assign w_idx    = i_addr[ADDR_W+1:2];
  assign w_unused = ^i_addr[31:ADDR_W+2];

  assign w_accept = (i_re | i_we) & ~w_busy;
  assign w_mis    = is_misaligned(i_size, i_addr[1:0]);
  assign w_store  = w_accept & i_we & ~w_mis;
  assign w_load   = w_accept & i_re & ~i_we;

  // Store data is replicated across lanes; byte enables pick the lane(s) actually written.
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        w_be           = 4'b0001 << i_addr[1:0];
        w_wlanes       = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be     = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{i_wdata[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wlanes = i_wdata;
      end
    endcase
  end

`ifdef DMEM_CLEAR_EN
  dmem_state_e       r_state;
  logic [ADDR_W-1:0] r_clr_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_idx <= r_clr_idx + 1'b1;
      if (r_clr_idx == ADDR_W'(DEPTH - 1)) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign w_busy    = (r_state == ST_CLEAR);
  assign w_clr_we  = w_busy & ~i_rst;
  assign w_clr_idx = r_clr_idx;
`else
  assign w_busy    = 1'b0;
  assign w_clr_we  = 1'b0;
  assign w_clr_idx = '0;
`endif

  // Array kept free of reset so it can map onto block RAM with byte enables.
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_store) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) begin
          r_mem[w_idx][l*8 +: 8] <= w_wlanes[l*8 +: 8];
        end
      end
    end
    r_p1_word <= r_mem[w_idx];
  end

  dmem_load_align u_align (
    .i_word     (r_p1_word),
    .i_off      (r_p1_off),
    .i_size     (r_p1_size),
    .i_unsigned (r_p1_uns),
    .o_data     (w_ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p1_load  <= 1'b0;
      r_p1_mis   <= 1'b0;
      r_p1_off   <= 2'b00;
      r_p1_size  <= 2'b00;
      r_p1_uns   <= 1'b0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_p1_load  <= w_load;
      r_p1_mis   <= w_accept & w_mis;
      r_p1_off   <= i_addr[1:0];
      r_p1_size  <= i_size;
      r_p1_uns   <= i_unsigned_ld;
      r_rvalid   <= r_p1_load;
      r_misalign <= r_p1_mis;
      if (r_p1_load) begin
        r_rdata <= r_p1_mis ? '0 : w_ld_data;
      end
    end
  end

  assign o_rdata      = r_rdata;
  assign o_rvalid     = r_rvalid;
  assign o_misalign   = r_misalign;
  assign o_busy       = w_busy;
  assign o_test_value = r_mem[0][15:0];

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench for data_mem_sized: table of single requests plus hand sequences for pipelining,
// store-to-load forwarding and (with DMEM_CLEAR_EN) the clear engine.
module tb_data_mem_sized;
  import mips_mem_pkg::*;

  localparam int unsigned DEPTH = 64;

  logic        clk;
  logic        rst;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misalign;
  logic        busy;
  logic [15:0] test_value;

  data_mem_sized #(.DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_re          (re),
    .i_we          (we),
    .i_addr        (addr),
    .i_size        (size),
    .i_unsigned_ld (uns),
    .i_wdata       (wdata),
    .o_rdata       (rdata),
    .o_rvalid      (rvalid),
    .o_misalign    (misalign),
    .o_busy        (busy),
    .o_test_value  (test_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_rv;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  function automatic vec_t mk(input string nm, input logic r, input logic w,
                              input logic [31:0] a, input logic [1:0] sz, input logic u,
                              input logic [31:0] wd, input logic crd, input logic [31:0] erd,
                              input logic erv, input logic emis);
    vec_t v;
    v.name = nm; v.re = r; v.we = w; v.addr = a; v.size = sz; v.uns = u; v.wdata = wd;
    v.chk_rd = crd; v.exp_rd = erd; v.exp_rv = erv; v.exp_mis = emis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [1:0] sz,
                     input logic u, input logic [31:0] wd);
    re = r; we = w; addr = a; size = sz; uns = u; wdata = wd;
  endtask

  task automatic idle();
    re = 1'b0; we = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    n_pass = 0; n_total = 0;
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; size = SZ_WORD; uns = 1'b0; wdata = '0;

    // Byte lanes of 0x80FF7F01 at 0x10: 01, 7F, FF, 80.
    vecs.push_back(mk("sw_10",     0, 1, 32'h10,  SZ_WORD, 0, 32'h80FF7F01, 0, 0, 0, 0));
    vecs.push_back(mk("lb_10",     1, 0, 32'h10,  SZ_BYTE, 0, 0, 1, 32'h00000001, 1, 0));
    vecs.push_back(mk("lbu_10",    1, 0, 32'h10,  SZ_BYTE, 1, 0, 1, 32'h00000001, 1, 0));
    vecs.push_back(mk("lb_11",     1, 0, 32'h11,  SZ_BYTE, 0, 0, 1, 32'h0000007F, 1, 0));
    vecs.push_back(mk("lb_12",     1, 0, 32'h12,  SZ_BYTE, 0, 0, 1, 32'hFFFFFFFF, 1, 0));
    vecs.push_back(mk("lbu_12",    1, 0, 32'h12,  SZ_BYTE, 1, 0, 1, 32'h000000FF, 1, 0));
    vecs.push_back(mk("lb_13",     1, 0, 32'h13,  SZ_BYTE, 0, 0, 1, 32'hFFFFFF80, 1, 0));
    vecs.push_back(mk("lbu_13",    1, 0, 32'h13,  SZ_BYTE, 1, 0, 1, 32'h00000080, 1, 0));
    vecs.push_back(mk("lh_10",     1, 0, 32'h10,  SZ_HALF, 0, 0, 1, 32'h00007F01, 1, 0));
    vecs.push_back(mk("lhu_10",    1, 0, 32'h10,  SZ_HALF, 1, 0, 1, 32'h00007F01, 1, 0));
    vecs.push_back(mk("lh_12",     1, 0, 32'h12,  SZ_HALF, 0, 0, 1, 32'hFFFF80FF, 1, 0));
    vecs.push_back(mk("lhu_12",    1, 0, 32'h12,  SZ_HALF, 1, 0, 1, 32'h000080FF, 1, 0));
    vecs.push_back(mk("sw_20",     0, 1, 32'h20,  SZ_WORD, 0, 32'h11223344, 0, 0, 0, 0));
    vecs.push_back(mk("sb_21",     0, 1, 32'h21,  SZ_BYTE, 0, 32'hFFFFFFAB, 1, 32'h000080FF, 0, 0));
    vecs.push_back(mk("lw_20_a",   1, 0, 32'h20,  SZ_WORD, 0, 0, 1, 32'h1122AB44, 1, 0));
    vecs.push_back(mk("sh_22",     0, 1, 32'h22,  SZ_HALF, 0, 32'h1234BEEF, 0, 0, 0, 0));
    vecs.push_back(mk("lw_20_b",   1, 0, 32'h20,  SZ_WORD, 0, 0, 1, 32'hBEEFAB44, 1, 0));
    vecs.push_back(mk("lh_22",     1, 0, 32'h22,  SZ_HALF, 0, 0, 1, 32'hFFFFBEEF, 1, 0));
    vecs.push_back(mk("lhu_22",    1, 0, 32'h22,  SZ_HALF, 1, 0, 1, 32'h0000BEEF, 1, 0));
    vecs.push_back(mk("sw_30",     0, 1, 32'h30,  SZ_WORD, 0, 32'hCAFEF00D, 0, 0, 0, 0));
    vecs.push_back(mk("sw_31_mis", 0, 1, 32'h31,  SZ_WORD, 0, 32'hFFFFFFFF, 1, 32'h0000BEEF, 0, 1));
    vecs.push_back(mk("sh_33_mis", 0, 1, 32'h33,  SZ_HALF, 0, 32'hFFFFFFFF, 0, 0, 0, 1));
    vecs.push_back(mk("lh_23_mis", 1, 0, 32'h23,  SZ_HALF, 0, 0, 1, 32'h00000000, 1, 1));
    vecs.push_back(mk("lw_30",     1, 0, 32'h30,  SZ_WORD, 0, 0, 1, 32'hCAFEF00D, 1, 0));
    vecs.push_back(mk("lw3_20",    1, 0, 32'h20,  2'b11,   0, 0, 1, 32'hBEEFAB44, 1, 0));
    vecs.push_back(mk("lw3_22_mis", 1, 0, 32'h22, 2'b11,   0, 0, 1, 32'h00000000, 1, 1));
    vecs.push_back(mk("lw_wrap",   1, 0, 32'h110, SZ_WORD, 0, 0, 1, 32'h80FF7F01, 1, 0));
    vecs.push_back(mk("rewe_40",   1, 1, 32'h40,  SZ_WORD, 0, 32'h55667788, 1, 32'h80FF7F01, 0, 0));
    vecs.push_back(mk("lw_40",     1, 0, 32'h40,  SZ_WORD, 0, 0, 1, 32'h55667788, 1, 0));
    vecs.push_back(mk("sb_33",     0, 1, 32'h33,  SZ_BYTE, 0, 32'h0000005A, 0, 0, 0, 0));
    vecs.push_back(mk("lw_30_b",   1, 0, 32'h30,  SZ_WORD, 0, 0, 1, 32'h5AFEF00D, 1, 0));

    step();
    step();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    rst = 1'b0;

`ifdef DMEM_CLEAR_EN
    n = 0;
    while (busy && n < 200) begin n++; step(); end
    chk("busy_len", 32'(n), 32'(DEPTH));
    req(1, 0, 32'h0, SZ_WORD, 0, 0);  step();
    req(1, 0, 32'hFC, SZ_WORD, 0, 0); step();
    chk("clr_lw_0", rdata, 32'h0);
    chk("clr_lw_0_rv", {31'b0, rvalid}, 32'h1);
    idle(); step();
    chk("clr_lw_fc", rdata, 32'h0);
    chk("clr_lw_fc_rv", {31'b0, rvalid}, 32'h1);
    step();
    chk("clr_rv_single", {31'b0, rvalid}, 32'h0);

    req(0, 1, 32'h0, SZ_WORD, 0, 32'hFFFFFFFF); step(); idle();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    n = 0; bad = 0;
    while (busy && n < 200) begin
      if (n[0]) req(0, 1, 32'h0, SZ_WORD, 0, 32'hDEADBEEF);
      else      req(1, 0, 32'h4, SZ_WORD, 0, 0);
      if (rvalid) bad++;
      n++;
      step();
    end
    idle();
    chk("busy_len_restart", 32'(n), 32'(DEPTH));
    chk("busy_no_rvalid", 32'(bad), 32'h0);
    chk("busy_no_write_tv", {16'h0, test_value}, 32'h0);
    req(1, 0, 32'h0, SZ_WORD, 0, 0); step(); idle(); step();
    chk("busy_no_write_lw", rdata, 32'h0);
`else
    chk("busy_tied_low", {31'b0, busy}, 32'h0);
`endif

    foreach (vecs[i]) begin
      req(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata);
      step();
      idle();
      step();
      chk({vecs[i].name, "_rvalid"}, {31'b0, rvalid}, {31'b0, vecs[i].exp_rv});
      chk({vecs[i].name, "_misalign"}, {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
      if (vecs[i].chk_rd) chk({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rd);
    end

    // test_value tap follows word 0 the cycle after the store edge.
    req(0, 1, 32'h0, SZ_WORD, 0, 32'h00001234); step(); idle();
    chk("tv_after_sw", {16'h0, test_value}, 32'h00001234);
    req(0, 1, 32'h2, SZ_HALF, 0, 32'h0000FFFF); step(); idle();
    chk("tv_upper_half", {16'h0, test_value}, 32'h00001234);

    req(0, 1, 32'h50, SZ_WORD, 0, 32'hA5A5A5A5); step();
    req(1, 0, 32'h50, SZ_WORD, 0, 0);            step();
    idle(); step();
    chk("st_ld_fwd", rdata, 32'hA5A5A5A5);
    chk("st_ld_fwd_rv", {31'b0, rvalid}, 32'h1);

    req(1, 0, 32'h10, SZ_WORD, 0, 0); step();
    req(1, 0, 32'h20, SZ_WORD, 0, 0); step();
    chk("b2b_first", rdata, 32'h80FF7F01);
    chk("b2b_first_rv", {31'b0, rvalid}, 32'h1);
    idle(); step();
    chk("b2b_second", rdata, 32'hBEEFAB44);
    chk("b2b_second_rv", {31'b0, rvalid}, 32'h1);
    step();
    chk("b2b_rv_drop", {31'b0, rvalid}, 32'h0);
    chk("b2b_rdata_hold", rdata, 32'hBEEFAB44);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
